// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks.
//   FWD_*       : E-stage operand select encodings (forwardae / forwardbe)
//   mem_state_e : data-memory wait FSM state encoding
//   reg_match   : register-address compare that never matches $0
package mips_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_W  = 2'b01;  // operand from W-stage result
    localparam logic [1:0] FWD_M  = 2'b10;  // operand from M-stage ALU result

    typedef enum logic {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } mem_state_e;

    // $0 is hard-wired to zero, so a source of 0 never depends on anything.
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory wait FSM with timeout.
//   clk, rst_n     : clock, asynchronous active-low reset
//   memreqm_i      : load/store active in M
//   dmem_ready_i   : data memory completes the M access this cycle
//   memstall_o     : freeze the pipeline for the outstanding access
//   memerr_o       : sticky flag, an access was abandoned on timeout
//   state_o        : current FSM state (debug visibility)
// RUN detects a not-ready access and stalls in the same cycle; MEMWAIT keeps
// stalling until ready or until tocnt reaches MEM_TIMEOUT. Ready beats timeout.
module mem_wait_fsm
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       memreqm_i,
    input  logic       dmem_ready_i,
    output logic       memstall_o,
    output logic       memerr_o,
    output mem_state_e state_o
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

    mem_state_e      state_q, state_d;
    logic [TO_W-1:0] tocnt_q, tocnt_d;
    logic            memerr_q, memerr_d;
    logic            memstall;
    logic            timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            tocnt_q  <= '0;
            memerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tocnt_q  <= tocnt_d;
            memerr_q <= memerr_d;
        end
    end

    assign timeout = (state_q == MEMWAIT) && (tocnt_q == TO_LIMIT);

    always_comb begin
        state_d  = state_q;
        tocnt_d  = tocnt_q;
        memerr_d = memerr_q;
        memstall = 1'b0;
        case (state_q)
            RUN: begin
                tocnt_d = '0;
                if (memreqm_i && !dmem_ready_i) begin
                    state_d  = MEMWAIT;
                    tocnt_d  = {{(TO_W-1){1'b0}}, 1'b1};
                    memstall = 1'b1;
                end
            end
            MEMWAIT: begin
                if (dmem_ready_i) begin
                    state_d = RUN;
                    tocnt_d = '0;
                end else if (timeout) begin
                    // Abandon the access and let the pipeline advance.
                    state_d  = RUN;
                    tocnt_d  = '0;
                    memerr_d = 1'b1;
                end else begin
                    memstall = 1'b1;
                    tocnt_d  = tocnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                tocnt_d = '0;
            end
        endcase
    end

    // The RUN-state term is combinational on inputs, so gate it while reset
    // is held: during reset only the pure hazard terms may drive stalls.
    assign memstall_o = memstall & rst_n;
    assign memerr_o   = memerr_q;
    assign state_o    = state_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the 5-stage MIPS core.
//   clk, rst_n                : clock, asynchronous active-low reset
//   rsd/rtd, rse/rte          : source registers in D / E
//   writerege/m/w, regwritee/m/w : destinations and write enables in E/M/W
//   memtorege/m               : load in E / M
//   branchd                   : branch resolved in D
//   memreqm, dmem_ready       : M-stage memory access and its completion
//   stallf..stallw, flushe    : stage holds and ID-EX bubble
//   forwardad/bd, forwardae/be: forwarding selects for D comparator / E ALU
//   memerr                    : sticky memory-timeout flag
//   stallcnt                  : saturating count of cycles with stallf=1
//   fsm_state                 : memory wait FSM state (debug)
module hazard_unit
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8,
    parameter int STALLCNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4:0]            rsd,
    input  logic [4:0]            rtd,
    input  logic [4:0]            rse,
    input  logic [4:0]            rte,
    input  logic [4:0]            writerege,
    input  logic [4:0]            writeregm,
    input  logic [4:0]            writeregw,
    input  logic                  regwritee,
    input  logic                  regwritem,
    input  logic                  regwritew,
    input  logic                  memtorege,
    input  logic                  memtoregm,
    input  logic                  branchd,
    input  logic                  memreqm,
    input  logic                  dmem_ready,
    output logic                  stallf,
    output logic                  stalld,
    output logic                  stalle,
    output logic                  stallm,
    output logic                  stallw,
    output logic                  flushe,
    output logic                  forwardad,
    output logic                  forwardbd,
    output logic [1:0]            forwardae,
    output logic [1:0]            forwardbe,
    output logic                  memerr,
    output logic [STALLCNT_W-1:0] stallcnt,
    output mem_state_e            fsm_state
);

    logic                  lwstall, branchstall, memstall, hazstall;
    logic [STALLCNT_W-1:0] stallcnt_q, stallcnt_d;

    mem_wait_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (TO_W)
    ) u_mem_wait_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .memreqm_i    (memreqm),
        .dmem_ready_i (dmem_ready),
        .memstall_o   (memstall),
        .memerr_o     (memerr),
        .state_o      (fsm_state)
    );

    // M has the newer value, so it wins over W.
    always_comb begin
        forwardae = FWD_RF;
        if (regwritem && reg_match(rse, writeregm))      forwardae = FWD_M;
        else if (regwritew && reg_match(rse, writeregw)) forwardae = FWD_W;
        forwardbe = FWD_RF;
        if (regwritem && reg_match(rte, writeregm))      forwardbe = FWD_M;
        else if (regwritew && reg_match(rte, writeregw)) forwardbe = FWD_W;
    end

    assign forwardad = regwritem && reg_match(rsd, writeregm);
    assign forwardbd = regwritem && reg_match(rtd, writeregm);

    assign lwstall = memtorege && (reg_match(rsd, rte) || reg_match(rtd, rte));

    // A branch compares in D, so an E-stage ALU result or an M-stage load
    // feeding it cannot be forwarded in time.
    assign branchstall = branchd &&
        ((regwritee && (reg_match(rsd, writerege) || reg_match(rtd, writerege))) ||
         (memtoregm && (reg_match(rsd, writeregm) || reg_match(rtd, writeregm))));

    assign hazstall = lwstall || branchstall;

    assign stallf = hazstall || memstall;
    assign stalld = stallf;
    assign stalle = memstall;
    assign stallm = memstall;
    assign stallw = memstall;
    // A frozen E stage must keep its instruction, so no bubble under memstall.
    assign flushe = hazstall && !memstall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stallcnt_q <= '0;
        else        stallcnt_q <= stallcnt_d;
    end

    always_comb begin
        stallcnt_d = stallcnt_q;
        if (stallf && (stallcnt_q != '1)) stallcnt_d = stallcnt_q + 1'b1;
    end

    assign stallcnt = stallcnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rsd, rtd, rse, rte, writerege, writeregm, writeregw;
    logic       regwritee, regwritem, regwritew, memtorege, memtoregm;
    logic       branchd, memreqm, dmem_ready;

    // u_dut: long timeout, wide counter. u_to: MEM_TIMEOUT=3, 2-bit counter.
    logic        d_stallf, d_stalld, d_stalle, d_stallm, d_stallw, d_flushe;
    logic        d_fad, d_fbd, d_memerr;
    logic [1:0]  d_fae, d_fbe;
    logic [31:0] d_stallcnt;
    mem_state_e  d_state;
    logic        t_stallf, t_stalld, t_stalle, t_stallm, t_stallw, t_flushe;
    logic        t_fad, t_fbd, t_memerr;
    logic [1:0]  t_fae, t_fbe;
    logic [1:0]  t_stallcnt;
    mem_state_e  t_state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_unit #(.MEM_TIMEOUT(255), .TO_W(8), .STALLCNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .rsd(rsd), .rtd(rtd), .rse(rse), .rte(rte),
        .writerege(writerege), .writeregm(writeregm), .writeregw(writeregw),
        .regwritee(regwritee), .regwritem(regwritem), .regwritew(regwritew),
        .memtorege(memtorege), .memtoregm(memtoregm), .branchd(branchd),
        .memreqm(memreqm), .dmem_ready(dmem_ready),
        .stallf(d_stallf), .stalld(d_stalld), .stalle(d_stalle), .stallm(d_stallm),
        .stallw(d_stallw), .flushe(d_flushe), .forwardad(d_fad), .forwardbd(d_fbd),
        .forwardae(d_fae), .forwardbe(d_fbe), .memerr(d_memerr),
        .stallcnt(d_stallcnt), .fsm_state(d_state)
    );

    hazard_unit #(.MEM_TIMEOUT(3), .TO_W(2), .STALLCNT_W(2)) u_to (
        .clk(clk), .rst_n(rst_n), .rsd(rsd), .rtd(rtd), .rse(rse), .rte(rte),
        .writerege(writerege), .writeregm(writeregm), .writeregw(writeregw),
        .regwritee(regwritee), .regwritem(regwritem), .regwritew(regwritew),
        .memtorege(memtorege), .memtoregm(memtoregm), .branchd(branchd),
        .memreqm(memreqm), .dmem_ready(dmem_ready),
        .stallf(t_stallf), .stalld(t_stalld), .stalle(t_stalle), .stallm(t_stallm),
        .stallw(t_stallw), .flushe(t_flushe), .forwardad(t_fad), .forwardbd(t_fbd),
        .forwardae(t_fae), .forwardbe(t_fbe), .memerr(t_memerr),
        .stallcnt(t_stallcnt), .fsm_state(t_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        rsd = 0; rtd = 0; rse = 0; rte = 0;
        writerege = 0; writeregm = 0; writeregw = 0;
        regwritee = 0; regwritem = 0; regwritew = 0;
        memtorege = 0; memtoregm = 0; branchd = 0;
        memreqm = 0; dmem_ready = 0;
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow a settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        tick();
        settle();
        check("rst_stallf", 32'(d_stallf), 32'd0);
        check("rst_stalle", 32'(d_stalle), 32'd0);
        check("rst_memerr", 32'(d_memerr), 32'd0);
        check("rst_stallcnt", d_stallcnt, 32'd0);
        check("rst_fae", 32'(d_fae), 32'd0);
        check("rst_state", 32'(d_state), 32'(RUN));
        tick();
        rst_n = 1'b1;

        // Forwarding priority and $0 exclusion.
        rse = 5; rte = 5; writeregm = 5; regwritem = 1; writeregw = 5; regwritew = 1;
        settle();
        check("fae_m", 32'(d_fae), 32'(2'b10));
        check("fbe_m", 32'(d_fbe), 32'(2'b10));
        regwritem = 0;
        settle();
        check("fae_w", 32'(d_fae), 32'(2'b01));
        rse = 0;
        settle();
        check("fae_r0", 32'(d_fae), 32'(2'b00));
        check("fbe_w", 32'(d_fbe), 32'(2'b01));
        clear_inputs();
        rsd = 7; writeregm = 7; regwritem = 1;
        settle();
        check("fad_hit", 32'(d_fad), 32'd1);
        check("fad_nostall", 32'(d_stallf), 32'd0);
        rsd = 0;
        settle();
        check("fad_r0", 32'(d_fad), 32'd0);
        clear_inputs();
        tick();

        // Load-use stall.
        memtorege = 1; rte = 8; rsd = 8;
        settle();
        check("lw_stallf", 32'(d_stallf), 32'd1);
        check("lw_stalld", 32'(d_stalld), 32'd1);
        check("lw_flushe", 32'(d_flushe), 32'd1);
        check("lw_stalle", 32'(d_stalle), 32'd0);
        tick();
        memtorege = 0;
        settle();
        check("lw_off_stallf", 32'(d_stallf), 32'd0);
        check("lw_off_flushe", 32'(d_flushe), 32'd0);
        clear_inputs();
        tick();

        // Branch hazards.
        branchd = 1; regwritee = 1; writerege = 3; rtd = 3;
        settle();
        check("br_e_stallf", 32'(d_stallf), 32'd1);
        check("br_e_flushe", 32'(d_flushe), 32'd1);
        regwritee = 0; writerege = 0; memtoregm = 1; writeregm = 3;
        settle();
        check("br_m_load_stallf", 32'(d_stallf), 32'd1);
        memtoregm = 0; regwritem = 1;
        settle();
        check("br_fwd_fbd", 32'(d_fbd), 32'd1);
        check("br_fwd_stallf", 32'(d_stallf), 32'd0);
        check("br_fwd_flushe", 32'(d_flushe), 32'd0);
        clear_inputs();
        tick();

        // Memory wait of 4 cycles under a concurrent load-use hazard.
        memtorege = 1; rte = 8; rsd = 8; memreqm = 1; dmem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("mw_stalle_%0d", i), 32'(d_stalle), 32'd1);
            check($sformatf("mw_stallw_%0d", i), 32'(d_stallw), 32'd1);
            check($sformatf("mw_flushe_%0d", i), 32'(d_flushe), 32'd0);
            tick();
        end
        dmem_ready = 1;
        settle();
        check("mw_ready_stalle", 32'(d_stalle), 32'd0);
        check("mw_ready_flushe", 32'(d_flushe), 32'd1);
        tick();
        clear_inputs();
        settle();
        check("mw_done_state", 32'(d_state), 32'(RUN));
        check("mw_done_memerr", 32'(d_memerr), 32'd0);

        // Timeout on u_to (MEM_TIMEOUT=3).
        do_reset();
        memreqm = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("to_stalle_%0d", i), 32'(t_stalle), 32'd1);
            tick();
        end
        settle();
        check("to_cycle_stalle", 32'(t_stalle), 32'd0);
        check("to_cycle_memerr", 32'(t_memerr), 32'd0);
        tick();
        memreqm = 0;
        settle();
        check("to_after_memerr", 32'(t_memerr), 32'd1);
        check("to_after_state", 32'(t_state), 32'(RUN));
        check("to_after_stallf", 32'(t_stallf), 32'd0);
        tick();
        settle();
        check("to_sticky_memerr", 32'(t_memerr), 32'd1);

        // Ready arriving on the timeout cycle wins.
        do_reset();
        memreqm = 1; dmem_ready = 0;
        tick(); tick(); tick();
        dmem_ready = 1;
        settle();
        check("torace_stalle", 32'(t_stalle), 32'd0);
        tick();
        memreqm = 0; dmem_ready = 0;
        settle();
        check("torace_memerr", 32'(t_memerr), 32'd0);
        check("torace_state", 32'(t_state), 32'(RUN));

        // Seven stalled cycles, then reset mid-MEMWAIT.
        do_reset();
        memreqm = 1; dmem_ready = 0; memtorege = 1; rte = 8; rsd = 8;
        for (int i = 0; i < 7; i++) tick();
        settle();
        check("pre_rst_stallcnt", d_stallcnt, 32'd7);
        check("pre_rst_stalle", 32'(d_stalle), 32'd1);
        check("pre_rst_state", 32'(d_state), 32'(MEMWAIT));
        check("sat_stallcnt", 32'(t_stallcnt), 32'd3);
        check("pre_rst_t_memerr", 32'(t_memerr), 32'd1);
        rst_n = 1'b0;
        settle();
        check("midrst_stalle", 32'(d_stalle), 32'd0);
        check("midrst_memerr", 32'(t_memerr), 32'd0);
        check("midrst_stallcnt", d_stallcnt, 32'd0);
        check("midrst_state", 32'(d_state), 32'(RUN));
        check("midrst_stallf", 32'(d_stallf), 32'd1);
        check("midrst_flushe", 32'(d_flushe), 32'd1);
        tick();
        clear_inputs();
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
